seq_mult_16: RTL



---
 rtl/seq_mult_16.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_mult_16.sv
// Iterative unsigned 16x16 shift-add multiplier: one partial-product step per clock,
// 32-bit product after 16 steps under a start/busy/done handshake.
module seq_mult_16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] P,
    output logic        busy,
    output logic        done
);

    // Handshake: start is sampled only in IDLE; busy is high for the 16 RUN cycles,
    // done is a one-cycle pulse when P has just been written; they are never high together.
    // One flop per output bit, so busy/done are direct register outputs and cannot glitch.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]  state;
    logic [15:0] mcand;
    logic [15:0] acc;
    logic [15:0] mlr;
    logic [3:0]  cnt;

    logic [8:0]  add_lo;
    logic [8:0]  add_hi0;
    logic [8:0]  add_hi1;
    logic [8:0]  add_hi;
    logic [15:0] sum;
    logic        cout;
    logic [31:0] next_prod;

    // 8-bit carry-lookahead adder: each carry is the flattened generate/propagate expression.
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       term;
        logic       prop;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & cin);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    // Upper half is computed for both carry-ins and selected by the lower half's carry out.
    always_comb begin
        add_lo  = cla8(acc[7:0], mcand[7:0], 1'b0);
        add_hi0 = cla8(acc[15:8], mcand[15:8], 1'b0);
        add_hi1 = cla8(acc[15:8], mcand[15:8], 1'b1);
        add_hi  = add_lo[8] ? add_hi1 : add_hi0;
        sum     = {add_hi[7:0], add_lo[7:0]};
        cout    = add_hi[8];
    end

    assign next_prod = mlr[0] ? {cout, sum, mlr[15:1]} : {1'b0, acc, mlr[15:1]};

    assign busy = state[0];
    assign done = state[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            mcand <= '0;
            acc   <= '0;
            mlr   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= A;
                        mlr   <= B;
                        acc   <= '0;
                        cnt   <= 4'd15;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    {acc, mlr} <= next_prod;
                    if (cnt == 4'd0) begin
                        P     <= next_prod;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
